// File: rtl/crypto_core.sv
// Crypto handshake responder: latches data/key/mode, runs ROUNDS rotate-xor rounds, holds fin_crypto until Store_data.
// Optional feature: define CRYPTO_ABORT_EN to let Load_data abort an operation in RUN or DONE.
module crypto_core #(
    parameter int DATA_W = 16,
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Load_data,
    input  logic              start_crypt,
    input  logic              start_decrypt,
    input  logic              start_execute_crypto,
    input  logic              Store_data,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key_in,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] key_out,
    output logic              data_out_valid,
    output logic              fin_crypto,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               mode_dec;
    logic               load_ok, start_ok, store_ok, round_last;
    logic [DATA_W-1:0]  round_key, round_d;
    int                 ridx;

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int n);
        logic [2*DATA_W-1:0] t;
        t = {x, x} << n;
        return t[2*DATA_W-1:DATA_W];
    endfunction

    assign round_last = (cnt == CNT_W'(ROUNDS - 1));
    assign dbg_state  = state;

    // Strobes are single-cycle level samples, no ready back-pressure: Load_data is taken in IDLE/LOADED,
    // start_execute_crypto only in LOADED, Store_data only in DONE; anything else is dropped.
    always_comb begin
        state_next = state;
        load_ok    = 1'b0;
        start_ok   = 1'b0;
        store_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (Load_data) begin
                    load_ok    = 1'b1;
                    state_next = LOADED;
                end
            end
            LOADED: begin
                load_ok = Load_data;
                if (start_execute_crypto) begin
                    start_ok   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
`ifdef CRYPTO_ABORT_EN
                if (Load_data) begin
                    load_ok    = 1'b1;
                    state_next = LOADED;
                end else if (round_last) begin
                    state_next = DONE;
                end
`else
                if (round_last) state_next = DONE;
`endif
            end
            DONE: begin
`ifdef CRYPTO_ABORT_EN
                if (Load_data) begin
                    load_ok    = 1'b1;
                    state_next = LOADED;
                end else if (Store_data) begin
                    store_ok   = 1'b1;
                    state_next = IDLE;
                end
`else
                if (Store_data) begin
                    store_ok   = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Decrypt walks the round keys backwards so it undoes encrypt step by step.
    always_comb begin
        ridx      = mode_dec ? (ROUNDS - 1 - int'(cnt)) : int'(cnt);
        round_key = rotl(key_out, ridx % DATA_W);
        if (mode_dec) round_d = rotl(data_out, DATA_W - 3) ^ round_key;
        else          round_d = rotl(data_out ^ round_key, 3);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            mode_dec       <= 1'b0;
            data_out       <= '0;
            key_out        <= '0;
            data_out_valid <= 1'b0;
            fin_crypto     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            busy           <= (state_next == RUN);
            fin_crypto     <= (state_next == DONE);
            data_out_valid <= store_ok;
            if (load_ok) begin
                data_out <= data_in;
                key_out  <= key_in;
                if (start_crypt)        mode_dec <= 1'b0;
                else if (start_decrypt) mode_dec <= 1'b1;
            end else if (state == RUN) begin
                data_out <= round_d;
            end
            if (start_ok)           cnt <= '0;
            else if (state == RUN)  cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: doc/crypto_core.md
# crypto_core

Responder side of the processor's crypto handshake. It latches a data word and key when the control unit loads them, and records the encrypt/decrypt mode at the same time. On command it runs a fixed number of invertible rounds, one per clock. It then holds `fin_crypto` high until the control unit collects the result with `Store_data`, and its outputs feed the data-memory write path.

## Interface
Parameters:
- `DATA_W`, 16: width of the data and key words.
- `ROUNDS`, 4: number of rounds; legal range 1..DATA_W-1.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset, synchronous and active-low.
- `Load_data` input 1: load strobe; captures `data_in` and `key_in`.
- `start_crypt` input 1: with `Load_data`, selects encrypt.
- `start_decrypt` input 1: with `Load_data`, selects decrypt.
- `start_execute_crypto` input 1: start-rounds strobe.
- `Store_data` input 1: result-collect strobe.
- `data_in` input DATA_W: plaintext or ciphertext.
- `key_in` input DATA_W: key.
- `data_out` output DATA_W: result register.
- `key_out` output DATA_W: latched key, used for key write-back.
- `data_out_valid` output 1: one-cycle pulse on an accepted `Store_data`.
- `fin_crypto` output 1: result ready.
- `busy` output 1: high in RUN.

## Operation
- States:
  - IDLE (reset)
  - LOADED
  - RUN
  - DONE
- Round keys: `k_i = rotl(key, i mod DATA_W)`.
- Encrypt: for i = 0..ROUNDS-1, `d = rotl(d ^ k_i, 3)`.
- Decrypt: for i = ROUNDS-1 down to 0, `d = rotr(d, 3) ^ k_i`.
- Decrypt exactly inverts encrypt for the same key.
- All arithmetic is modulo DATA_W bits; there is no carry.
- IDLE or LOADED with `Load_data` = 1:
  - Latch data, key and mode, then go to LOADED.
  - Mode: `start_crypt` gives encrypt. `start_decrypt` alone gives decrypt. Both high gives encrypt.
  - Neither high: mode is unchanged; the reset mode is encrypt.
- LOADED with `start_execute_crypto` = 1:
  - Go to RUN and clear the round counter.
  - If the same cycle also has `Load_data`, load first and still go to RUN with the new operands.
- `start_execute_crypto` in IDLE is ignored; `fin_crypto` stays 0.
- RUN:
  - Perform one round per clock and increment the counter.
  - After round ROUNDS-1, go to DONE and set `fin_crypto`.
- `Load_data` and `start_execute_crypto` in RUN are ignored, unless CRYPTO_ABORT_EN is defined.
- DONE:
  - `fin_crypto` holds high.
  - On `Store_data`: pulse `data_out_valid`, clear `fin_crypto`, go to IDLE.
  - `Load_data` in DONE is ignored.
- `Store_data` outside DONE has no effect: `data_out_valid` stays 0 and `data_out` is unchanged.
- `data_out` always shows the working register. `key_out` shows the latched key and is unchanged by the rounds.
- Reset values: every output is 0, the state is IDLE, the mode is encrypt.
- Reset asserted mid-RUN returns to IDLE on the next edge and discards the partial result.

## Timing
- Every output is registered; there are no combinational paths from inputs to outputs.
- Load accepted at edge N gives LOADED from N.
- Start accepted at edge S:
  - `busy` is high from S.
  - `fin_crypto` is high after edge S+ROUNDS; `busy` is low at the same time.
- Start-to-fin latency is ROUNDS cycles.
- `Store_data` sampled at edge T:
  - `data_out_valid` is high for exactly the cycle after T.
  - `fin_crypto` is low after T.
- Minimum full transaction is ROUNDS+3 edges: load, start, ROUNDS rounds, store. This matches the control unit's SEND_KEY → ACTIV → CHECK_END → MEM_WRITE sequence.

## Configuration
- `CRYPTO_ABORT_EN` defined:
  - `Load_data` in RUN or DONE aborts the operation.
  - It clears `fin_crypto` and `busy`, latches the new operands and mode, and goes to LOADED.
- `CRYPTO_ABORT_EN` undefined: `Load_data` in RUN or DONE is ignored, as described above.

## Test plan
All scenarios use DATA_W=16, ROUNDS=4.
- Encrypt: load data 0x1234, key 0x00FF with `start_crypt`, then start. `fin_crypto` rises 4 cycles after the start edge with `data_out`=0x8DEF. Intermediate values are 0x9658, 0xBD34, 0xF645.
- Decrypt: load data 0x8DEF, key 0x00FF with `start_decrypt`, then start. `data_out`=0x1234, and `key_out`=0x00FF throughout.
- Handshake: hold `Store_data` low for 5 cycles in DONE, so `fin_crypto` stays 1. Then pulse `Store_data`: `data_out_valid` goes high for 1 cycle, `fin_crypto` goes to 0, state IDLE.
- Ignored strobes:
  - `start_execute_crypto` in IDLE gives no `busy` and no `fin_crypto`.
  - `Store_data` in IDLE gives no `data_out_valid`.
  - `start_crypt` and `start_decrypt` high together select encrypt, giving 0x8DEF for the vectors above.
- Reset mid-RUN: assert `rst`=0 after 2 rounds. Next edge: all outputs 0, IDLE. A fresh encrypt of 0x1234/0x00FF then yields 0x8DEF.
- `Load_data` in RUN with new data 0xAAAA:
  - Without CRYPTO_ABORT_EN: the result is still 0x8DEF.
  - With CRYPTO_ABORT_EN: `busy` drops, state LOADED, and `data_out` is 0xAAAA before the restart.
